// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (SZ_*)
//   - FSM state enum
//   - WORD_BYTES and derived lane-address width
//   - latched request struct
//   - alignment helpers
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LO_BITS    = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_e;

  // Only the fields still needed after accept are kept; the word address
  // goes straight into mem_a at accept time.
  typedef struct packed {
    logic               we;
    logic [1:0]         size;
    logic               zext;
    logic [LO_BITS-1:0] lo;
    logic [31:0]        wdata;
  } lsu_req_t;

  function automatic logic misaligned(logic [1:0] size, logic [LO_BITS-1:0] lo);
    return (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != '0);
  endfunction

  // Clear the low address bits down to the natural alignment of the size.
  function automatic logic [31:0] align_addr(logic [1:0] size, logic [31:0] addr);
    case (size)
      SZ_HALF: return {addr[31:1], 1'b0};
      SZ_WORD: return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational lane extract / merge.
//   word    : word read from memory
//   lo      : byte offset within the word
//   size    : access size (SZ_*)
//   zext    : 1 = zero-extend loads, 0 = sign-extend
//   wdata   : right-aligned store data
//   ld_data : extracted and extended load data
//   st_word : word with the addressed byte/half replaced by wdata
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0]        word,
  input  logic [LO_BITS-1:0] lo,
  input  logic [1:0]         size,
  input  logic               zext,
  input  logic [31:0]        wdata,
  output logic [31:0]        ld_data,
  output logic [31:0]        st_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word[{lo, 3'b000} +: 8];
    h       = lo[1] ? word[31:16] : word[15:0];
    ld_data = word;
    st_word = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{b[7] & ~zext}}, b};
        st_word = word;
        st_word[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{h[15] & ~zext}}, h};
        st_word = word;
        if (lo[1]) st_word[31:16] = wdata[15:0];
        else       st_word[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of a
// combinational-read, posedge-write word memory.
//   clk, rst (async, active low)
//   req_*      : request handshake; fields latched at accept
//   resp_*     : one-cycle completion pulse with extended load data / error
//   mem_*      : word memory port (mem_rd is combinational on mem_a)
// Config: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses; otherwise they are silently aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state;
  lsu_req_t    cur;
  logic        acc, err;
  logic [31:0] acc_addr, ld_data, st_word;

  always_comb begin
    acc = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    acc_addr = req_addr;
    err = (req_size == SZ_ILL) || ({2'b00, req_addr[31:2]} >= WORDS) ||
          misaligned(req_size, req_addr[LO_BITS-1:0]);
`else
    acc_addr = align_addr(req_size, req_addr);
    err = (req_size == SZ_ILL) || ({2'b00, req_addr[31:2]} >= WORDS);
`endif
  end

  lsu_byte_lane u_lane (
    .word    (mem_rd),
    .lo      (cur.lo),
    .size    (cur.size),
    .zext    (cur.zext),
    .wdata   (cur.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // All outputs are registered and updated alongside the state, so they
  // already hold the values of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur        <= '0;
      req_ready  <= 1'b1;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          cur       <= '{we: req_we, size: req_size, zext: req_unsigned,
                         lo: acc_addr[LO_BITS-1:0], wdata: req_wdata};
          req_ready <= 1'b0;
          if (err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (req_we && req_size == SZ_WORD) begin
            // Full-word stores need no read-modify-write.
            state  <= WRITE;
            mem_we <= 1'b1;
            mem_a  <= {acc_addr[31:LO_BITS], {LO_BITS{1'b0}}};
            mem_wd <= req_wdata;
          end else begin
            state <= READ;
            mem_a <= {acc_addr[31:LO_BITS], {LO_BITS{1'b0}}};
          end
        end
        READ: begin
          if (cur.we) begin
            state  <= WRITE;
            mem_we <= 1'b1;
            mem_wd <= st_word;
          end else begin
            state      <= RESP;
            mem_a      <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_we     <= 1'b0;
          mem_a      <= '0;
          mem_wd     <= '0;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORDS, default 1024, giving the number of 32-bit words in the attached memory.
REQ-002 SHALL have ports `clk` (input, 1, sole clock) and `rst` (input, 1); reset is asynchronous and active-low.
REQ-003 SHALL have `req_valid` (input, 1): a request is offered.
REQ-004 SHALL have `req_ready` (output, 1): the unit accepts a request.
REQ-005 SHALL have `req_we` (input, 1): 1 = store, 0 = load.
REQ-006 SHALL have `req_size` (input, 2): 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-007 SHALL have `req_unsigned` (input, 1): zero-extend loads when 1, sign-extend when 0.
REQ-008 SHALL have `req_addr` (input, 32): byte address.
REQ-009 SHALL have `req_wdata` (input, 32): store data, right-aligned.
REQ-010 SHALL have `resp_valid` (output, 1): one-cycle completion pulse.
REQ-011 SHALL have `resp_rdata` (output, 32): extended load data; 0 for stores and errors.
REQ-012 SHALL have `resp_err` (output, 1): request rejected.
REQ-013 SHALL have `mem_we` (output, 1), `mem_a` (output, 32) and `mem_wd` (output, 32) for the word memory; memory writes on posedge `clk`.
REQ-014 SHALL have `mem_rd` (input, 32): combinational read data of word `mem_a[31:2]`.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, RESP.
- `req_ready` = 1 only in IDLE.
- Accept occurs on `req_valid` && `req_ready`; all `req_*` fields are latched at accept.
REQ-016 SHALL drive `mem_a` = {latched addr[31:2], 2'b00} in READ and WRITE, and 0 otherwise.
- `mem_we` = 1 only in WRITE.
REQ-017 Transitions after an accept at edge N:
- Load: READ at N+1 (capture `mem_rd`), RESP at N+2.
- Store word: WRITE at N+1, RESP at N+2.
- Store byte/half: READ at N+1, WRITE at N+2 (merged word), RESP at N+3.
- Error: RESP at N+1.
REQ-018 RESP SHALL assert `resp_valid` for exactly one cycle, then return to IDLE. The next accept is possible at the following edge.
REQ-019 Load extraction SHALL select the lane by addr[1:0] and extend to 32 bits per `req_unsigned`.
- Example: byte 0x80, signed → 0xFFFFFF80.
REQ-020 Sub-word store merge SHALL replace only the addressed byte or half of the captured word and preserve the other bytes.
REQ-021 Error conditions, each causing no memory access and `resp_err` = 1:
- `req_size` = 11.
- addr[31:2] >= WORDS.
- Misalignment, as set by REQ-025.
REQ-022 `req_*` changes while not in IDLE SHALL have no effect.
REQ-023 `resp_err` and `resp_rdata` SHALL be 0 whenever `resp_valid` = 0.

Reset
REQ-024 `rst` low SHALL immediately force:
- state IDLE;
- `req_ready` = 1;
- `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0;
- `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0.
An in-flight access is abandoned; a WRITE is suppressed if reset asserts before the write edge.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN SHALL control misaligned requests (half with addr[0] = 1, or word with addr[1:0] != 0):
- Defined: the request is an error.
- Undefined: the low address bits are cleared to natural alignment and the access proceeds with `resp_err` = 0.

Structure
REQ-026 Package `lsu_pkg` SHALL hold:
- size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
- the FSM state enum;
- constant WORD_BYTES = 4.
REQ-027 Lane extract and merge logic SHALL live in the combinational sub-module `lsu_byte_lane`, which is instantiated once.

Verification
REQ-028 Preload word 7 = 0x8899AABB; load byte, signed, addr 0x1D → resp at N+2, `resp_rdata` = 0xFFFFFFAA, `resp_err` = 0.
REQ-029 Store half 0x1234 to addr 0x1E over word 0x8899AABB → `mem_we` at N+2 with `mem_wd` = 0x1234AABB; resp at N+3.
REQ-030 Store word 0xDEADBEEF to addr 0x70 → `mem_we` at N+1 with `mem_a` = 0x70; resp at N+2; a following load returns 0xDEADBEEF.
REQ-031 Load word at addr 0x1002 → with the macro: resp at N+1, `resp_err` = 1, no `mem_we`; without the macro: reads addr 0x1000 and `resp_err` = 0, unless that address is out of range.
REQ-032 Load word at addr 0x1000 with WORDS = 1024 → `resp_err` = 1 at N+1.
REQ-033 Assert `rst` low during the READ of a sub-word store → `mem_we` is never 1, `req_ready` = 1 immediately, and the memory word is unchanged.
